load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter DEPTH, default 32: number of 32-bit words in the downstream data memory; legal word index range is 0..DEPTH-1.
REQ-002 clock  in  1  rising-edge clock for all state.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 reqValid  in  1  request present.
REQ-005 reqReady  out  1  unit accepts a request this cycle.
REQ-006 reqWrite  in  1  1=store, 0=load.
REQ-007 reqSize  in  2  00=byte, 01=halfword, 10=word; 11 is treated as word.
REQ-008 reqUnsigned  in  1  load zero-extends when 1, sign-extends when 0.
REQ-009 reqAddress  in  32  byte address from the ALU.
REQ-010 reqWriteData  in  32  store data, right-aligned.
REQ-011 respValid  out  1  one-cycle completion pulse.
REQ-012 respData  out  32  extended load result; 0 for stores and errors.
REQ-013 respError  out  1  request rejected with no memory access; qualified by respValid.
REQ-014 memAddress  out  32  word index, reqAddress[31:2].
REQ-015 memWriteData  out  32  full word to data memory.
REQ-016 memWrite  out  1  data memory write strobe.
REQ-017 memRead  out  1  data memory read strobe.
REQ-018 memReadData  in  32  data memory output, valid the cycle after memRead.

Function
REQ-019 The FSM SHALL use states IDLE, READ, CAPTURE, WRITE and RESP.
REQ-020 IDLE: reqReady=1; a request is accepted when reqValid=1; all request fields SHALL be latched at acceptance.
REQ-021 Accepted load, or byte/half store -> READ; word store -> WRITE; error -> RESP.
REQ-022 READ SHALL assert memRead for exactly one cycle, then go to CAPTURE.
REQ-023 CAPTURE SHALL register memReadData; a load then goes to RESP, a store goes to WRITE.
REQ-024 WRITE SHALL assert memWrite for exactly one cycle, then go to RESP.
REQ-025 Store merge SHALL be little-endian: byte lane k=addr[1:0] replaces bits [8k+7:8k]; a halfword at addr[1] replaces bits [16*addr[1]+15:16*addr[1]]; other bits keep the captured word.
REQ-026 Load extraction SHALL use the same lanes, then sign- or zero-extend the result to 32 bits per reqUnsigned; a word load is passed through unchanged.
REQ-027 RESP SHALL assert respValid for exactly one cycle (no back-pressure), then return to IDLE.
REQ-028 Latency from the acceptance cycle T SHALL be:
  - load: respValid at T+3
  - word store: memWrite at T+1, respValid at T+2
  - byte/half store: memRead at T+1, memWrite at T+3, respValid at T+4
  - error: respValid at T+1
REQ-029 A word index >= DEPTH SHALL be an error: no memRead or memWrite, respError=1.
REQ-030 memRead and memWrite SHALL never assert together; both SHALL be 0 outside READ and WRITE; memAddress SHALL be held stable from acceptance until the next acceptance.

Reset
REQ-031 While reset=0: state=IDLE, reqReady=0, respValid=0, respError=0, respData=0, memRead=0, memWrite=0, memWriteData=0, memAddress=0.
REQ-032 Reset mid-operation SHALL abandon the request with no later memWrite or respValid; reqReady=1 in the first cycle after release.

Configuration
REQ-033 With LSU_MISALIGN_TRAP_EN defined, a misaligned access (halfword with addr[0]=1, or word with addr[1:0]!=0) SHALL be an error per REQ-021/REQ-029.
REQ-034 Without LSU_MISALIGN_TRAP_EN, the address SHALL be force-aligned (halfword clears bit0, word clears bits[1:0]) and processed normally; respError is asserted only for out-of-range accesses.

Verification
REQ-035 Signed byte load, addr 0x17, memReadData=0x80FF1234 -> memAddress=5, respData=0xFFFFFF80 at T+3.
REQ-036 Unsigned halfword load, addr 0x16, memReadData=0x80FF1234 -> respData=0x000080FF.
REQ-037 Byte store 0xAB at addr 0x15, word 5 reads 0x11223344 -> memWrite at T+3 with 0x1122AB44, respValid at T+4.
REQ-038 Word store 0xDEADBEEF at addr 0x20 -> memWrite at T+1 to index 8; addr 0x80 -> respError=1 at T+1 with no strobe.
REQ-039 Word load at addr 0x22:
  - with LSU_MISALIGN_TRAP_EN: respError at T+1, no memRead
  - without: memRead to index 8
REQ-040 Byte store accepted, reset pulsed low during READ -> no memWrite, no respValid, reqReady=1 after release.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: byte/halfword/word loads and read-modify-write sub-word stores to a word memory.
// Optional feature macro LSU_MISALIGN_TRAP_EN: misaligned half/word accesses become errors instead of being force-aligned.
module load_store_unit #(
    parameter int DEPTH = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic        reqWrite,
    input  logic [1:0]  reqSize,
    input  logic        reqUnsigned,
    input  logic [31:0] reqAddress,
    input  logic [31:0] reqWriteData,
    output logic        respValid,
    output logic [31:0] respData,
    output logic        respError,
    output logic [31:0] memAddress,
    output logic [31:0] memWriteData,
    output logic        memWrite,
    output logic        memRead,
    input  logic [31:0] memReadData,
    output logic [2:0]  dbgState
);

    // Handshake: a request transfers on a rising edge where reqValid and reqReady are both high;
    // respValid is a single-cycle pulse with no back-pressure, and respData/respError are valid only with it.

    typedef enum logic [2:0] {IDLE, READ, CAPTURE, WRITE, RESP} state_t;

    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    state_t      state_q;
    logic        write_q;
    logic [1:0]  size_q;
    logic        unsigned_q;
    logic [1:0]  off_q;
    logic [31:0] wdata_q;
    logic        resp_valid_q;
    logic        resp_error_q;
    logic [31:0] resp_data_q;
    logic [31:0] mem_address_q;
    logic [31:0] mem_wdata_q;
    logic        mem_write_q;
    logic        mem_read_q;

    logic        is_half;
    logic        is_word;
    logic [1:0]  req_off_d;
    logic        req_error_d;

    assign is_half = (reqSize == 2'b01);
    assign is_word = reqSize[1];

    always_comb begin
        req_off_d = reqAddress[1:0];
        if (is_half) begin
            req_off_d[0] = 1'b0;
        end
        if (is_word) begin
            req_off_d = 2'b00;
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign req_error_d = ({2'b00, reqAddress[31:2]} >= DEPTH_W)
                       || (is_half && reqAddress[0])
                       || (is_word && (reqAddress[1:0] != 2'b00));
`else
    assign req_error_d = ({2'b00, reqAddress[31:2]} >= DEPTH_W);
`endif

    function automatic logic [31:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   return 32'h0000_00FF << {off, 3'b000};
            2'b01:   return 32'h0000_FFFF << {off[1], 4'b0000};
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                                 input logic [1:0] off, input logic uns);
        logic [31:0] sh;
        sh = word >> {off, 3'b000};
        case (size)
            2'b00:   return uns ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            2'b01:   return uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: return word;
        endcase
    endfunction

    // Captured word keeps every bit outside the addressed lanes.
    function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [31:0] wdata,
                                                input logic [1:0] size, input logic [1:0] off);
        logic [31:0] mask;
        mask = lane_mask(size, off);
        return (word & ~mask) | ((wdata << {off, 3'b000}) & mask);
    endfunction

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            write_q       <= 1'b0;
            size_q        <= 2'b00;
            unsigned_q    <= 1'b0;
            off_q         <= 2'b00;
            wdata_q       <= 32'h0;
            resp_valid_q  <= 1'b0;
            resp_error_q  <= 1'b0;
            resp_data_q   <= 32'h0;
            mem_address_q <= 32'h0;
            mem_wdata_q   <= 32'h0;
            mem_write_q   <= 1'b0;
            mem_read_q    <= 1'b0;
        end else begin
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (reqValid) begin
                        write_q       <= reqWrite;
                        size_q        <= reqSize;
                        unsigned_q    <= reqUnsigned;
                        off_q         <= req_off_d;
                        wdata_q       <= reqWriteData;
                        mem_address_q <= {2'b00, reqAddress[31:2]};
                        if (req_error_d) begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_error_q <= 1'b1;
                        end else if (reqWrite && is_word) begin
                            state_q     <= WRITE;
                            mem_write_q <= 1'b1;
                            mem_wdata_q <= reqWriteData;
                        end else begin
                            state_q    <= READ;
                            mem_read_q <= 1'b1;
                        end
                    end
                end
                READ: begin
                    state_q <= CAPTURE;
                end
                CAPTURE: begin
                    if (write_q) begin
                        state_q     <= WRITE;
                        mem_write_q <= 1'b1;
                        mem_wdata_q <= store_merge(memReadData, wdata_q, size_q, off_q);
                    end else begin
                        state_q      <= RESP;
                        resp_valid_q <= 1'b1;
                        resp_data_q  <= load_extract(memReadData, size_q, off_q, unsigned_q);
                    end
                end
                WRITE: begin
                    state_q      <= RESP;
                    resp_valid_q <= 1'b1;
                end
                RESP: begin
                    state_q      <= IDLE;
                    resp_data_q  <= 32'h0;
                    resp_error_q <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign reqReady     = reset && (state_q == IDLE);
    assign respValid    = resp_valid_q;
    assign respData     = resp_data_q;
    assign respError    = resp_error_q;
    assign memAddress   = mem_address_q;
    assign memWriteData = mem_wdata_q;
    assign memWrite     = mem_write_q;
    assign memRead      = mem_read_q;
    assign dbgState     = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-array memory reference model, directed cases, random traffic and reset abort.
module tb_load_store_unit;

    localparam int DEPTH = 32;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        reqValid, reqReady, reqWrite, reqUnsigned;
    logic [1:0]  reqSize;
    logic [31:0] reqAddress, reqWriteData;
    logic        respValid, respError, memWrite, memRead;
    logic [31:0] respData, memAddress, memWriteData;
    logic [31:0] memReadData;
    logic [2:0]  dbgState;

    int total = 0;
    int bad = 0;

    logic [31:0] tb_mem [DEPTH];
    logic [7:0]  ref_bytes [4*DEPTH];
    logic [31:0] exp_q [$];

    logic [31:0] last_rdata, last_wr_data, last_err;

    load_store_unit #(.DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite), .reqSize(reqSize),
        .reqUnsigned(reqUnsigned), .reqAddress(reqAddress), .reqWriteData(reqWriteData),
        .respValid(respValid), .respData(respData), .respError(respError),
        .memAddress(memAddress), .memWriteData(memWriteData), .memWrite(memWrite),
        .memRead(memRead), .memReadData(memReadData), .dbgState(dbgState)
    );

    // Clock and memory environment (read data appears the cycle after memRead).
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (memRead && memAddress < DEPTH) memReadData <= tb_mem[int'(memAddress)];
        if (memWrite && memAddress < DEPTH) tb_mem[int'(memAddress)] <= memWriteData;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input logic wr, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd);
        int nb, ea, rd_exp, wr_exp, resp_exp;
        int rd_n, wr_n, resp_n, rd_cyc, wr_cyc, resp_cyc, both;
        logic err, oor, mis, ready_after;
        logic [63:0] v;
        logic [31:0] exp_wword, wr_data, rdata, rerr, addr_k1;

        // Reference model: byte-addressed little-endian memory.
        nb  = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        oor = (addr >> 2) >= DEPTH;
        mis = (addr & 32'(nb - 1)) != 0;
`ifdef LSU_MISALIGN_TRAP_EN
        err = oor || mis;
`else
        err = oor;
`endif
        ea = int'(addr & ~32'(nb - 1));
        exp_wword = 32'h0;
        v = 64'h0;
        if (!err) begin
            if (wr) begin
                for (int b = 0; b < nb; b++) ref_bytes[ea + b] = wd[8*b +: 8];
                for (int b = 0; b < 4; b++) exp_wword[8*b +: 8] = ref_bytes[(ea & ~3) + b];
            end else begin
                for (int b = 0; b < nb; b++) v = v | (64'(ref_bytes[ea + b]) << (8 * b));
                if (!uns && nb < 4 && v[8*nb-1]) v = v | ~((64'd1 << (8 * nb)) - 64'd1);
            end
        end
        exp_q.push_back((wr || err) ? 32'h0 : v[31:0]);
        rd_exp   = (err || (wr && nb == 4)) ? 0 : 1;
        wr_exp   = (err || !wr) ? 0 : ((nb == 4) ? 1 : 3);
        resp_exp = err ? 1 : (!wr ? 3 : ((nb == 4) ? 2 : 4));

        @(negedge clock);
        check("ready_before_req", {31'b0, reqReady}, 32'd1);
        reqValid = 1'b1; reqWrite = wr; reqSize = sz; reqUnsigned = uns;
        reqAddress = addr; reqWriteData = wd;
        @(posedge clock);
        rd_n = 0; wr_n = 0; resp_n = 0; rd_cyc = 0; wr_cyc = 0; resp_cyc = 0; both = 0;
        wr_data = 32'hFFFF_FFFF; rdata = 32'hFFFF_FFFF; rerr = 32'hFFFF_FFFF;
        addr_k1 = 32'hFFFF_FFFF; ready_after = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clock);
            if (k == 1) begin
                reqValid = 1'b0;
                addr_k1 = memAddress;
            end
            if (memRead && memWrite) both++;
            if (memRead) begin rd_n++; rd_cyc = k; end
            if (memWrite) begin wr_n++; wr_cyc = k; wr_data = memWriteData; end
            if (respValid) begin
                resp_n++; resp_cyc = k; rdata = respData; rerr = {31'b0, respError};
            end
            if (k == resp_exp + 1) ready_after = reqReady;
        end
        check("mem_address", addr_k1, addr >> 2);
        check("mem_address_hold", memAddress, addr >> 2);
        check("read_cycle", 32'(rd_cyc), 32'(rd_exp));
        check("read_count", 32'(rd_n), (rd_exp != 0) ? 32'd1 : 32'd0);
        check("write_cycle", 32'(wr_cyc), 32'(wr_exp));
        check("write_count", 32'(wr_n), (wr_exp != 0) ? 32'd1 : 32'd0);
        check("resp_cycle", 32'(resp_cyc), 32'(resp_exp));
        check("resp_count", 32'(resp_n), 32'd1);
        check("resp_error", rerr, {31'b0, err});
        check("resp_data", rdata, exp_q.pop_front());
        check("strobe_overlap", 32'(both), 32'd0);
        check("ready_after_resp", {31'b0, ready_after}, 32'd1);
        if (wr_exp != 0) check("write_data", wr_data, exp_wword);
        last_rdata = rdata; last_wr_data = wr_data; last_err = rerr;
    endtask

    initial begin
        int wr_n, resp_n;
        logic [31:0] addr;
        reqValid = 1'b0; reqWrite = 1'b0; reqSize = 2'b00; reqUnsigned = 1'b0;
        reqAddress = 32'h0; reqWriteData = 32'h0;

        // Reset state.
        repeat (2) @(negedge clock);
        check("rst_reqReady", {31'b0, reqReady}, 32'd0);
        check("rst_respValid", {31'b0, respValid}, 32'd0);
        check("rst_respError", {31'b0, respError}, 32'd0);
        check("rst_respData", respData, 32'h0);
        check("rst_memRead", {31'b0, memRead}, 32'd0);
        check("rst_memWrite", {31'b0, memWrite}, 32'd0);
        check("rst_memWriteData", memWriteData, 32'h0);
        check("rst_memAddress", memAddress, 32'h0);
        reset = 1'b1;
        #1 check("ready_after_release", {31'b0, reqReady}, 32'd1);

        // Fill memory with random words through the unit.
        for (int i = 0; i < DEPTH; i++) do_req(1'b1, 2'b10, 1'b0, 32'(i * 4), $urandom());

        // Byte store merge into word 5.
        do_req(1'b1, 2'b10, 1'b0, 32'h14, 32'h1122_3344);
        do_req(1'b1, 2'b00, 1'b0, 32'h15, 32'h0000_00AB);
        check("byte_store_merge", last_wr_data, 32'h1122_AB44);

        // Signed byte and unsigned halfword loads.
        do_req(1'b1, 2'b10, 1'b0, 32'h14, 32'h80FF_1234);
        do_req(1'b0, 2'b00, 1'b0, 32'h17, 32'h0);
        check("signed_byte_load", last_rdata, 32'hFFFF_FF80);
        do_req(1'b0, 2'b01, 1'b1, 32'h16, 32'h0);
        check("unsigned_half_load", last_rdata, 32'h0000_80FF);

        // Word store in range, then first out-of-range index.
        do_req(1'b1, 2'b10, 1'b0, 32'h20, 32'hDEAD_BEEF);
        check("word_store_data", last_wr_data, 32'hDEAD_BEEF);
        do_req(1'b1, 2'b10, 1'b0, 32'h80, 32'hDEAD_BEEF);
        check("out_of_range_error", last_err, 32'd1);

        // Misaligned word load.
        do_req(1'b0, 2'b10, 1'b0, 32'h22, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
        check("misaligned_word_error", last_err, 32'd1);
`else
        check("misaligned_word_data", last_rdata, 32'hDEAD_BEEF);
`endif

        // Reset pulsed while a byte store is in READ.
        @(negedge clock);
        reqValid = 1'b1; reqWrite = 1'b1; reqSize = 2'b00; reqUnsigned = 1'b0;
        reqAddress = 32'h15; reqWriteData = 32'h0000_0077;
        @(posedge clock);
        @(negedge clock);
        reqValid = 1'b0;
        check("abort_in_read", {31'b0, memRead}, 32'd1);
        reset = 1'b0;
        #1;
        check("abort_rst_reqReady", {31'b0, reqReady}, 32'd0);
        check("abort_rst_memRead", {31'b0, memRead}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        #1 check("abort_ready_after_release", {31'b0, reqReady}, 32'd1);
        wr_n = 0; resp_n = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            if (memWrite) wr_n++;
            if (respValid) resp_n++;
        end
        check("abort_no_write", 32'(wr_n), 32'd0);
        check("abort_no_resp", 32'(resp_n), 32'd0);

        // Random traffic.
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 9) == 0) addr = $urandom();
            else addr = {32'($urandom_range(0, DEPTH + 3)) << 2} | 32'($urandom_range(0, 3));
            do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   addr, $urandom());
        end

        // Read back every word.
        for (int i = 0; i < DEPTH; i++) do_req(1'b0, 2'b10, 1'b0, 32'(i * 4), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
